cam_drain: RTL and testbench
============================

CAM_DRAIN -- requirements
Module: cam_drain

Interface
REQ-001 SHALL have parameters: CAM_DW, default 32, CAM data width; CAM_MW, default 3, mask width; CAM_AW, default 8, CAM address width; FIFO_DEPTH, default 4, result FIFO entries (power of 2, >=2); MAX_RETRY, default 15, miss retries (4-bit).
REQ-002 SHALL have ports: clk  in  1  sole clock; rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous assert, active-high.
REQ-004 SHALL have ports: req_valid  in  1; req_ready  out  1; req_mask  in  CAM_MW; req_strb  in  CAM_MW; these form the search request handshake.
REQ-005 SHALL have ports: cam_mask_in  out  CAM_MW; cam_mask_strb  out  CAM_MW; cam_mask_en  out  1; these drive the CAM search.
REQ-006 SHALL have ports: cam_hit  in  1; cam_data_out  in  CAM_DW; cam_addr_out  in  CAM_AW; these are the combinational CAM result.
REQ-007 SHALL have port cam_data_valid  out  1, the accept pulse that clears the first-hit CAM line.
REQ-008 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_hit  out  1; rsp_data  out  CAM_DW; rsp_addr  out  CAM_AW.
REQ-009 SHALL have ports: hit_cnt  out  16 and miss_cnt  out  16, saturating statistics counters.

Function
REQ-010 SHALL implement FSM states IDLE and LOOKUP.
REQ-011 IDLE: req_ready SHALL be 1 iff FIFO count < FIFO_DEPTH; on req_valid&&req_ready, latch req_mask/req_strb and go to LOOKUP.
REQ-012 IDLE: cam_mask_en SHALL be 0 and cam_data_valid SHALL be 0; req_ready SHALL be 0 in LOOKUP.
REQ-013 LOOKUP: cam_mask_en SHALL be 1, and cam_mask_in/cam_mask_strb SHALL be the latched values.
REQ-014 LOOKUP with cam_hit=1: in the same cycle, SHALL assert cam_data_valid for exactly one cycle, push {hit=1, cam_data_out, cam_addr_out}, increment hit_cnt, and return to IDLE.
REQ-015 LOOKUP with cam_hit=0: SHALL keep cam_data_valid at 0; the miss path follows REQ-025/REQ-026.
REQ-016 A miss push SHALL write {hit=0, data=0, addr=0} and increment miss_cnt.
REQ-017 The FIFO slot SHALL be reserved at request acceptance; a LOOKUP push never finds the FIFO full.
REQ-018 Latency: request accepted at cycle N; LOOKUP at N+1; rsp_valid at N+2 when the FIFO was empty.
REQ-019 rsp_valid SHALL equal (count != 0); rsp_* SHALL show the FIFO head; a pop occurs on rsp_valid&&rsp_ready.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and preserve order; read/write pointers wrap modulo FIFO_DEPTH.
REQ-021 A full FIFO with rsp_ready=0 SHALL hold req_ready=0 and hold all rsp_* outputs stable.
REQ-022 hit_cnt and miss_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-023 rst=1 SHALL immediately force: state IDLE; FIFO count and pointers 0; retry counter 0; hit_cnt=miss_cnt=0; latched mask/strb 0.
REQ-024 During reset, SHALL drive req_ready=0, rsp_valid=0, cam_mask_en=0 and cam_data_valid=0; reset during LOOKUP SHALL discard the request with no CAM clear issued; FIFO storage need not be reset.

Configuration
REQ-025 With macro CAM_DRAIN_RETRY_EN defined: a LOOKUP miss SHALL stay in LOOKUP and increment a 4-bit retry counter; when the counter equals MAX_RETRY and the lookup still misses, SHALL push a miss, clear the counter and go to IDLE; a hit on any retry follows REQ-014 and clears the counter.
REQ-026 Without CAM_DRAIN_RETRY_EN: a LOOKUP miss SHALL push a miss and return to IDLE in that same cycle; no retry counter logic SHALL exist.

Verification
REQ-027 CAM line 5 holds 0xA0000001, cam_hit=1, req_mask=3'b101, req_strb=3'b111 -> exactly one cam_data_valid pulse at N+1; at N+2 rsp_hit=1, rsp_data=0xA0000001, rsp_addr=5; hit_cnt=1.
REQ-028 Macro off, cam_hit=0 -> at N+2 rsp_hit=0, rsp_data=0; miss_cnt=1; cam_data_valid never asserted.
REQ-029 Macro on, cam_hit=0 for 3 LOOKUP cycles then 1 -> single hit response; miss_cnt=0; all-miss case -> miss after 16 LOOKUP cycles.
REQ-030 rsp_ready=0 with 4 back-to-back hit requests -> FIFO full, req_ready=0; then rsp_ready=1 -> 4 responses in request order with addresses intact.
REQ-031 rst asserted in LOOKUP -> same cycle: cam_mask_en=0, rsp_valid=0; after release: counters 0, state IDLE, next request served normally.
REQ-032 Force hit_cnt to 16'hFFFF, then one hit -> hit_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/cam_drain.sv
// ---------------------------------------------------------------------------
// cam_drain
// Serialises search requests into a CAM, drains the first-hit line on each
// hit (cam_data_valid clears it) and queues {hit, data, addr} results in a
// small FIFO for a downstream consumer.
//
// Ports
//   clk, rst                          clock (rising edge), async active-high reset
//   req_valid/req_ready               search request handshake
//   req_mask/req_strb                 search mask and strobe, latched on accept
//   cam_mask_in/cam_mask_strb         latched mask/strobe driven to the CAM
//   cam_mask_en                       CAM search enable (high in LOOKUP)
//   cam_hit/cam_data_out/cam_addr_out combinational CAM result
//   cam_data_valid                    one-cycle accept pulse clearing the hit line
//   rsp_valid/rsp_ready               result FIFO head handshake
//   rsp_hit/rsp_data/rsp_addr         result FIFO head contents
//   hit_cnt/miss_cnt                  saturating statistics counters
//
// Build option
//   CAM_DRAIN_RETRY_EN : a missing lookup is retried up to MAX_RETRY extra
//                        times before a miss is reported.
// ---------------------------------------------------------------------------
module cam_drain #(
    parameter int CAM_DW     = 32,
    parameter int CAM_MW     = 3,
    parameter int CAM_AW     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_RETRY  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CAM_MW-1:0] req_mask,
    input  logic [CAM_MW-1:0] req_strb,
    output logic [CAM_MW-1:0] cam_mask_in,
    output logic [CAM_MW-1:0] cam_mask_strb,
    output logic              cam_mask_en,
    input  logic              cam_hit,
    input  logic [CAM_DW-1:0] cam_data_out,
    input  logic [CAM_AW-1:0] cam_addr_out,
    output logic              cam_data_valid,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [CAM_DW-1:0] rsp_data,
    output logic [CAM_AW-1:0] rsp_addr,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [0:0]  ST_IDLE   = 1'b0;
    localparam logic [0:0]  ST_LOOKUP = 1'b1;

    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [15:0]   STAT_MAX = 16'hFFFF;
    localparam logic [15:0]   STAT_ONE = 16'h0001;

    // Reject parameter values the pointer and retry arithmetic cannot represent.
    if (FIFO_DEPTH < 2 || (1 << PW) != FIFO_DEPTH || MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_param_check
        $error("cam_drain: FIFO_DEPTH must be a power of 2 >= 2 and MAX_RETRY must fit in 4 bits");
    end

    logic [0:0]        state_q, state_d;
    logic [CAM_MW-1:0] mask_q, mask_d;
    logic [CAM_MW-1:0] strb_q, strb_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic [15:0]       hit_cnt_q, hit_cnt_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;
`ifdef CAM_DRAIN_RETRY_EN
    logic [3:0]        retry_q, retry_d;
`endif

    logic              fifo_hit_q  [FIFO_DEPTH];
    logic [CAM_DW-1:0] fifo_data_q [FIFO_DEPTH];
    logic [CAM_AW-1:0] fifo_addr_q [FIFO_DEPTH];

    logic              push_s;
    logic              push_hit_s;
    logic [CAM_DW-1:0] push_data_s;
    logic [CAM_AW-1:0] push_addr_s;
    logic              pop_s;
    logic              hit_inc_s;
    logic              miss_inc_s;
    logic              ready_s;
    logic              lookup_en_s;
    logic              clear_s;

    // Request/lookup sequencing and result generation.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        strb_d      = strb_q;
        push_s      = 1'b0;
        push_hit_s  = 1'b0;
        push_data_s = '0;
        push_addr_s = '0;
        hit_inc_s   = 1'b0;
        miss_inc_s  = 1'b0;
        ready_s     = 1'b0;
        lookup_en_s = 1'b0;
        clear_s     = 1'b0;
`ifdef CAM_DRAIN_RETRY_EN
        retry_d     = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Only one request is ever in flight, so a free slot seen
                // here is still free when the lookup pushes its result.
                ready_s = (count_q < CNT_FULL);
                if (req_valid && ready_s) begin
                    mask_d  = req_mask;
                    strb_d  = req_strb;
                    state_d = ST_LOOKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                lookup_en_s = 1'b1;
                if (cam_hit) begin
                    clear_s     = 1'b1;
                    push_s      = 1'b1;
                    push_hit_s  = 1'b1;
                    push_data_s = cam_data_out;
                    push_addr_s = cam_addr_out;
                    hit_inc_s   = 1'b1;
                    state_d     = ST_IDLE;
`ifdef CAM_DRAIN_RETRY_EN
                    retry_d     = 4'd0;
`endif
                end else begin
`ifdef CAM_DRAIN_RETRY_EN
                    if (retry_q == 4'(MAX_RETRY)) begin
                        push_s     = 1'b1;
                        miss_inc_s = 1'b1;
                        retry_d    = 4'd0;
                        state_d    = ST_IDLE;
                    end else begin
                        retry_d    = retry_q + 4'd1;
                        state_d    = ST_LOOKUP;
                    end
`else
                    push_s     = 1'b1;
                    miss_inc_s = 1'b1;
                    state_d    = ST_IDLE;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer/occupancy and saturating statistics next-state.
    always_comb begin
        pop_s    = (count_q != '0) && rsp_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (hit_inc_s && (hit_cnt_q != STAT_MAX)) begin
            hit_cnt_d = hit_cnt_q + STAT_ONE;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if (miss_inc_s && (miss_cnt_q != STAT_MAX)) begin
            miss_cnt_d = miss_cnt_q + STAT_ONE;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Control and statistics registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            strb_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
`ifdef CAM_DRAIN_RETRY_EN
            retry_q    <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            strb_q     <= strb_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
`ifdef CAM_DRAIN_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    // Result storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            fifo_hit_q[wr_ptr_q]  <= push_hit_s;
            fifo_data_q[wr_ptr_q] <= push_data_s;
            fifo_addr_q[wr_ptr_q] <= push_addr_s;
        end
    end

    // Handshake and CAM strobes are forced low while reset is held.
    assign req_ready      = ready_s && !rst;
    assign cam_mask_en    = lookup_en_s && !rst;
    assign cam_data_valid = clear_s && !rst;
    assign cam_mask_in    = mask_q;
    assign cam_mask_strb  = strb_q;
    assign rsp_valid      = (count_q != '0) && !rst;
    assign rsp_hit        = fifo_hit_q[rd_ptr_q];
    assign rsp_data       = fifo_data_q[rd_ptr_q];
    assign rsp_addr       = fifo_addr_q[rd_ptr_q];
    assign hit_cnt        = hit_cnt_q;
    assign miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_cam_drain.sv
module tb_cam_drain;

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
        logic [7:0]  addr;
    } rsp_t;

`ifdef CAM_DRAIN_RETRY_EN
    localparam int MISS_LOOKUPS = 16;
`else
    localparam int MISS_LOOKUPS = 1;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_mask;
    logic [2:0]  req_strb;
    logic [2:0]  cam_mask_in;
    logic [2:0]  cam_mask_strb;
    logic        cam_mask_en;
    logic        cam_hit;
    logic [31:0] cam_data_out;
    logic [7:0]  cam_addr_out;
    logic        cam_data_valid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_addr;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int checks = 0;
    int errors = 0;
    rsp_t exp_q[$];

    // CAM model: a line is valid while its load generation differs from its clear generation.
    logic [31:0] line_data [8];
    int load_gen [8] = '{default: 0};
    int clr_gen  [8] = '{default: 0};
    int miss_cfg   = 0;
    int lookup_cnt = 0;
    int dv_pulses  = 0;
    int en_cycles  = 0;

    cam_drain dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_mask       (req_mask),
        .req_strb       (req_strb),
        .cam_mask_in    (cam_mask_in),
        .cam_mask_strb  (cam_mask_strb),
        .cam_mask_en    (cam_mask_en),
        .cam_hit        (cam_hit),
        .cam_data_out   (cam_data_out),
        .cam_addr_out   (cam_addr_out),
        .cam_data_valid (cam_data_valid),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_hit        (rsp_hit),
        .rsp_data       (rsp_data),
        .rsp_addr       (rsp_addr),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lowest valid line answers, after miss_cfg forced-miss lookup cycles.
    always_comb begin
        cam_hit      = 1'b0;
        cam_data_out = 32'h0;
        cam_addr_out = 8'h0;
        if (cam_mask_en && (lookup_cnt >= miss_cfg)) begin
            for (int i = 7; i >= 0; i--) begin
                if (load_gen[i] != clr_gen[i]) begin
                    cam_hit      = 1'b1;
                    cam_data_out = line_data[i];
                    cam_addr_out = 8'(i);
                end
            end
        end
    end

    // Lookup-cycle counter and line clearing on the accept pulse.
    always @(posedge clk) begin
        lookup_cnt <= cam_mask_en ? lookup_cnt + 1 : 0;
        if (cam_data_valid) begin
            clr_gen[cam_addr_out[2:0]] <= load_gen[cam_addr_out[2:0]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Activity counters and scoreboard monitor, sampled on the falling edge.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (cam_data_valid === 1'b1) dv_pulses++;
            if (cam_mask_en === 1'b1) en_cycles++;
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'({rsp_hit, rsp_data, rsp_addr}), 64'h0 - 64'h1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_payload", 64'({rsp_hit, rsp_data, rsp_addr}), 64'(e));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_line(input int idx, input logic [31:0] d);
        line_data[idx] = d;
        load_gen[idx]  = load_gen[idx] + 1;
    endtask

    // Present a request and hold it until accepted; returns in the LOOKUP cycle.
    task automatic send_req(input logic [2:0] m, input logic [2:0] s);
        logic acc;
        int   k;
        acc = 1'b0;
        k   = 0;
        req_mask  = m;
        req_strb  = s;
        req_valid = 1'b1;
        while (!acc && k < 40) begin
            acc = req_ready;
            step();
            k++;
        end
        req_valid = 1'b0;
        chk("req_accept", 64'(acc), 64'h1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || rsp_valid) && k < 100) begin
            step();
            k++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int dv0;
        int en0;
        int exp_hits;
        int exp_misses;
        exp_hits   = 0;
        exp_misses = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_mask  = 3'b000;
        req_strb  = 3'b000;
        rsp_ready = 1'b1;
        step();
        step();
        // Reset state
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_cam_en", 64'(cam_mask_en), 64'h0);
        chk("rst_cam_dv", 64'(cam_data_valid), 64'h0);
        chk("rst_hit_cnt", 64'(hit_cnt), 64'h0);
        chk("rst_miss_cnt", 64'(miss_cnt), 64'h0);
        chk("rst_mask", 64'({cam_mask_in, cam_mask_strb}), 64'h0);
        rst = 1'b0;
        step();
        chk("idle_req_ready", 64'(req_ready), 64'h1);

        // Single hit on line 5
        load_line(5, 32'hA000_0001);
        dv0 = dv_pulses;
        exp_q.push_back('{hit: 1'b1, data: 32'hA000_0001, addr: 8'd5});
        exp_hits++;
        send_req(3'b101, 3'b111);
        chk("hit_cam_en", 64'(cam_mask_en), 64'h1);
        chk("hit_cam_mask", 64'(cam_mask_in), 64'h5);
        chk("hit_cam_strb", 64'(cam_mask_strb), 64'h7);
        chk("hit_cam_dv", 64'(cam_data_valid), 64'h1);
        chk("lookup_req_ready", 64'(req_ready), 64'h0);
        chk("hit_rsp_early", 64'(rsp_valid), 64'h0);
        step();
        chk("hit_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("hit_dv_off", 64'(cam_data_valid), 64'h0);
        chk("hit_cnt_1", 64'(hit_cnt), 64'(exp_hits));
        drain();
        chk("hit_dv_pulses", 64'(dv_pulses - dv0), 64'h1);

        // Miss: no valid lines remain
        dv0 = dv_pulses;
        en0 = en_cycles;
        exp_q.push_back('{hit: 1'b0, data: 32'h0, addr: 8'h0});
        exp_misses++;
        send_req(3'b011, 3'b001);
        chk("miss_cam_dv", 64'(cam_data_valid), 64'h0);
`ifndef CAM_DRAIN_RETRY_EN
        step();
        chk("miss_rsp_valid", 64'(rsp_valid), 64'h1);
`endif
        drain();
        chk("miss_cnt_1", 64'(miss_cnt), 64'(exp_misses));
        chk("miss_hit_cnt", 64'(hit_cnt), 64'(exp_hits));
        chk("miss_dv_pulses", 64'(dv_pulses - dv0), 64'h0);
        chk("miss_lookups", 64'(en_cycles - en0), 64'(MISS_LOOKUPS));

`ifdef CAM_DRAIN_RETRY_EN
        // Three missing lookups, then a hit on the retry
        load_line(2, 32'h5555_0002);
        miss_cfg = 3;
        dv0 = dv_pulses;
        en0 = en_cycles;
        exp_q.push_back('{hit: 1'b1, data: 32'h5555_0002, addr: 8'd2});
        exp_hits++;
        send_req(3'b001, 3'b001);
        drain();
        miss_cfg = 0;
        chk("retry_lookups", 64'(en_cycles - en0), 64'h4);
        chk("retry_dv_pulses", 64'(dv_pulses - dv0), 64'h1);
        chk("retry_miss_cnt", 64'(miss_cnt), 64'(exp_misses));
        chk("retry_hit_cnt", 64'(hit_cnt), 64'(exp_hits));
`endif

        // Fill the FIFO with the consumer stalled
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            load_line(i, 32'hC000_0000 + 32'(i));
            exp_q.push_back('{hit: 1'b1, data: 32'hC000_0000 + 32'(i), addr: 8'(i)});
            exp_hits++;
        end
        for (int i = 0; i < 4; i++) begin
            send_req(3'(i), 3'b111);
        end
        step();
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("full_req_ready", 64'(req_ready), 64'h0);
            chk("full_rsp_valid", 64'(rsp_valid), 64'h1);
            chk("full_head", 64'({rsp_hit, rsp_data, rsp_addr}), 64'({1'b1, 32'hC000_0001, 8'd1}));
            step();
        end
        req_valid = 1'b0;
        // Release the consumer while two more requests overlap the drain
        load_line(6, 32'hD000_0006);
        load_line(7, 32'hD000_0007);
        exp_q.push_back('{hit: 1'b1, data: 32'hD000_0006, addr: 8'd6});
        exp_q.push_back('{hit: 1'b1, data: 32'hD000_0007, addr: 8'd7});
        exp_hits += 2;
        rsp_ready = 1'b1;
        send_req(3'b110, 3'b010);
        send_req(3'b111, 3'b100);
        drain();
        chk("order_hit_cnt", 64'(hit_cnt), 64'(exp_hits));

        // Reset asserted during LOOKUP discards the request
        load_line(3, 32'hBEEF_0003);
        dv0 = dv_pulses;
        send_req(3'b010, 3'b011);
        rst = 1'b1;
        #1;
        chk("rstlk_cam_en", 64'(cam_mask_en), 64'h0);
        chk("rstlk_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rstlk_cam_dv", 64'(cam_data_valid), 64'h0);
        chk("rstlk_req_ready", 64'(req_ready), 64'h0);
        step();
        step();
        rst = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        step();
        chk("rstlk_hit_cnt", 64'(hit_cnt), 64'h0);
        chk("rstlk_miss_cnt", 64'(miss_cnt), 64'h0);
        chk("rstlk_idle", 64'({req_ready, rsp_valid, cam_mask_en}), 64'h4);
        chk("rstlk_no_clear", 64'(dv_pulses - dv0), 64'h0);
        exp_q.push_back('{hit: 1'b1, data: 32'hBEEF_0003, addr: 8'd3});
        exp_hits++;
        send_req(3'b100, 3'b100);
        drain();
        chk("rstlk_after_hit", 64'(hit_cnt), 64'(exp_hits));

        // Saturation of hit_cnt
        @(negedge clk);
        force dut.hit_cnt_d = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.hit_cnt_d;
        step();
        chk("sat_preload", 64'(hit_cnt), 64'hFFFF);
        load_line(0, 32'h0000_00F0);
        exp_q.push_back('{hit: 1'b1, data: 32'h0000_00F0, addr: 8'd0});
        send_req(3'b001, 3'b111);
        drain();
        chk("sat_hit_cnt", 64'(hit_cnt), 64'hFFFF);

        step();
        chk("sb_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
